// File: rtl/vliw_pkg.sv
// Shared constants and opcode encoding for the 3-issue VLIW pipeline.
package vliw_pkg;

  localparam int NREGS  = 16;
  localparam int REG_AW = 4;
  localparam int DATA_W = 64;
  localparam int NPIPE  = 3;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_MUL  = 4'b1001,
    OP_LD   = 4'b1010,
    OP_MOV  = 4'b1011,
    OP_LUI  = 4'b1100,
    OP_SLT  = 4'b1101,
    OP_SLTU = 4'b1110,
    OP_CUST = 4'b1111
  } opcode_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters with busy vector and sticky error flag.
// Only instantiated when WB_SCOREBOARD_EN is defined.
module wb_scoreboard
  import vliw_pkg::*;
#(
  parameter int NP     = NPIPE,
  parameter int PEND_W = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [NP-1:0]                issue_valid,
  input  logic [NP-1:0][REG_AW-1:0]    issue_dest,
  input  logic [2*NP-1:0]              retire_valid,
  input  logic [2*NP-1:0][REG_AW-1:0]  retire_dest,
  output logic [NREGS-1:0]             busy,
  output logic                         sberr
);

  localparam int SUM_W = PEND_W + 3;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << PEND_W) - 1);

  logic [NREGS-1:0] clamp;
  logic             sberr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [PEND_W-1:0] count_reg;
      logic [PEND_W-1:0] count_next;
      logic [SUM_W-1:0]  inc_cnt;
      logic [SUM_W-1:0]  dec_cnt;
      logic [SUM_W-1:0]  sum_cnt;
      logic              clamp_next;

      // Increment and decrement are folded into one update so that an issue
      // and a retire in the same cycle cancel instead of racing.
      always_comb begin
        inc_cnt    = '0;
        dec_cnt    = '0;
        clamp_next = 1'b0;
        count_next = '0;
        for (int p = 0; p < NP; p++) begin
          if (issue_valid[p] && (issue_dest[p] == REG_AW'(gi)))
            inc_cnt = inc_cnt + SUM_W'(1);
        end
        for (int p = 0; p < 2 * NP; p++) begin
          if (retire_valid[p] && (retire_dest[p] == REG_AW'(gi)))
            dec_cnt = dec_cnt + SUM_W'(1);
        end
        sum_cnt = SUM_W'(count_reg) + inc_cnt;
        if (sum_cnt < dec_cnt) begin
          clamp_next = 1'b1;
          count_next = '0;
        end else if ((sum_cnt - dec_cnt) > CNT_MAX) begin
          clamp_next = 1'b1;
          count_next = CNT_MAX[PEND_W-1:0];
        end else begin
          count_next = PEND_W'(sum_cnt - dec_cnt);
        end
      end

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
          count_reg <= '0;
        else if (flush)
          count_reg <= '0;
        else
          count_reg <= count_next;
      end

      assign busy[gi]  = |count_reg;
      assign clamp[gi] = clamp_next;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      sberr_reg <= 1'b0;
    else if (!flush && |clamp)
      sberr_reg <= 1'b1;
  end

  assign sberr = sberr_reg;

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: registers three execute results, resolves same-destination
// conflicts (higher pipe wins) and drives the register file write ports.
// The pending-write scoreboard exists only when WB_SCOREBOARD_EN is defined.
module writeback_unit
  import vliw_pkg::*;
#(
  parameter int NPIPE  = vliw_pkg::NPIPE,
  parameter int PEND_W = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        e2w_validpipe1,
  input  logic [3:0]  e2w_instpipe1,
  input  logic [3:0]  e2w_destpipe1,
  input  logic [63:0] e2w_datapipe1,
  input  logic        e2w_validpipe2,
  input  logic [3:0]  e2w_instpipe2,
  input  logic [3:0]  e2w_destpipe2,
  input  logic [63:0] e2w_datapipe2,
  input  logic        e2w_validpipe3,
  input  logic [3:0]  e2w_instpipe3,
  input  logic [3:0]  e2w_destpipe3,
  input  logic [63:0] e2w_datapipe3,
  input  logic        d2w_issuepipe1,
  input  logic [3:0]  d2w_destpipe1,
  input  logic        d2w_issuepipe2,
  input  logic [3:0]  d2w_destpipe2,
  input  logic        d2w_issuepipe3,
  input  logic [3:0]  d2w_destpipe3,
  output logic [63:0] w2re_datapipe1,
  output logic        w2r_wrpipe1,
  output logic [3:0]  w2re_destpipe1,
  output logic [63:0] w2re_datapipe2,
  output logic        w2r_wrpipe2,
  output logic [3:0]  w2re_destpipe2,
  output logic [63:0] w2re_datapipe3,
  output logic        w2r_wrpipe3,
  output logic [3:0]  w2re_destpipe3,
  output logic [15:0] w2d_busy,
  output logic        w2d_sberr
);

  logic [NPIPE-1:0]              e_valid;
  logic [NPIPE-1:0][3:0]         e_inst;
  logic [NPIPE-1:0][REG_AW-1:0]  e_dest;
  logic [NPIPE-1:0][DATA_W-1:0]  e_data;
  logic [NPIPE-1:0]              want;
  logic [NPIPE-1:0]              supp;
  logic [NPIPE-1:0]              wr_q;
  logic [NPIPE-1:0]              supp_q;
  logic [NPIPE-1:0][REG_AW-1:0]  dest_q;
  logic [NPIPE-1:0][DATA_W-1:0]  data_q;

  assign e_valid = {e2w_validpipe3, e2w_validpipe2, e2w_validpipe1};
  assign e_inst  = {e2w_instpipe3,  e2w_instpipe2,  e2w_instpipe1};
  assign e_dest  = {e2w_destpipe3,  e2w_destpipe2,  e2w_destpipe1};
  assign e_data  = {e2w_datapipe3,  e2w_datapipe2,  e2w_datapipe1};

  always_comb begin
    want = '0;
    supp = '0;
    for (int p = 0; p < NPIPE; p++)
      want[p] = e_valid[p] && (e_inst[p] != OP_NOP);
    for (int p = 0; p < NPIPE; p++) begin
      for (int q = p + 1; q < NPIPE; q++) begin
        if (want[p] && want[q] && (e_dest[q] == e_dest[p]))
          supp[p] = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPIPE; gi++) begin : g_pipe
      logic              wr_reg;
      logic              supp_reg;
      logic [DATA_W-1:0] data_reg;
      logic [REG_AW-1:0] dest_reg;

      // dest_reg also records the target of a suppressed result, which the
      // scoreboard retires alongside the winning write.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          wr_reg   <= 1'b0;
          supp_reg <= 1'b0;
          data_reg <= '0;
          dest_reg <= '0;
        end else begin
          wr_reg   <= want[gi] && !supp[gi] && !flush;
          supp_reg <= want[gi] && supp[gi] && !flush;
          if (want[gi]) begin
            data_reg <= e_data[gi];
            dest_reg <= e_dest[gi];
          end
        end
      end

      assign wr_q[gi]   = wr_reg;
      assign supp_q[gi] = supp_reg;
      assign dest_q[gi] = dest_reg;
      assign data_q[gi] = data_reg;
    end
  endgenerate

  assign w2r_wrpipe1    = wr_q[0];
  assign w2r_wrpipe2    = wr_q[1];
  assign w2r_wrpipe3    = wr_q[2];
  assign w2re_destpipe1 = dest_q[0];
  assign w2re_destpipe2 = dest_q[1];
  assign w2re_destpipe3 = dest_q[2];
  assign w2re_datapipe1 = data_q[0];
  assign w2re_datapipe2 = data_q[1];
  assign w2re_datapipe3 = data_q[2];

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard #(
    .NP     (NPIPE),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clock        (clock),
    .reset_n      (reset_n),
    .flush        (flush),
    .issue_valid  ({d2w_issuepipe3, d2w_issuepipe2, d2w_issuepipe1}),
    .issue_dest   ({d2w_destpipe3, d2w_destpipe2, d2w_destpipe1}),
    .retire_valid ({supp_q, wr_q}),
    .retire_dest  ({dest_q, dest_q}),
    .busy         (w2d_busy),
    .sberr        (w2d_sberr)
  );
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{d2w_issuepipe1, d2w_destpipe1, d2w_issuepipe2,
                              d2w_destpipe2, d2w_issuepipe3, d2w_destpipe3,
                              supp_q, 1'(PEND_W)};
  assign w2d_busy  = 16'h0;
  assign w2d_sberr = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit; scoreboard expectations follow WB_SCOREBOARD_EN.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset_n, flush;
  logic        e2w_validpipe1, e2w_validpipe2, e2w_validpipe3;
  logic [3:0]  e2w_instpipe1, e2w_instpipe2, e2w_instpipe3;
  logic [3:0]  e2w_destpipe1, e2w_destpipe2, e2w_destpipe3;
  logic [63:0] e2w_datapipe1, e2w_datapipe2, e2w_datapipe3;
  logic        d2w_issuepipe1, d2w_issuepipe2, d2w_issuepipe3;
  logic [3:0]  d2w_destpipe1, d2w_destpipe2, d2w_destpipe3;
  logic [63:0] w2re_datapipe1, w2re_datapipe2, w2re_datapipe3;
  logic        w2r_wrpipe1, w2r_wrpipe2, w2r_wrpipe3;
  logic [3:0]  w2re_destpipe1, w2re_destpipe2, w2re_destpipe3;
  logic [15:0] w2d_busy;
  logic        w2d_sberr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  writeback_unit dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .e2w_validpipe1(e2w_validpipe1), .e2w_instpipe1(e2w_instpipe1),
    .e2w_destpipe1(e2w_destpipe1), .e2w_datapipe1(e2w_datapipe1),
    .e2w_validpipe2(e2w_validpipe2), .e2w_instpipe2(e2w_instpipe2),
    .e2w_destpipe2(e2w_destpipe2), .e2w_datapipe2(e2w_datapipe2),
    .e2w_validpipe3(e2w_validpipe3), .e2w_instpipe3(e2w_instpipe3),
    .e2w_destpipe3(e2w_destpipe3), .e2w_datapipe3(e2w_datapipe3),
    .d2w_issuepipe1(d2w_issuepipe1), .d2w_destpipe1(d2w_destpipe1),
    .d2w_issuepipe2(d2w_issuepipe2), .d2w_destpipe2(d2w_destpipe2),
    .d2w_issuepipe3(d2w_issuepipe3), .d2w_destpipe3(d2w_destpipe3),
    .w2re_datapipe1(w2re_datapipe1), .w2r_wrpipe1(w2r_wrpipe1), .w2re_destpipe1(w2re_destpipe1),
    .w2re_datapipe2(w2re_datapipe2), .w2r_wrpipe2(w2r_wrpipe2), .w2re_destpipe2(w2re_destpipe2),
    .w2re_datapipe3(w2re_datapipe3), .w2r_wrpipe3(w2r_wrpipe3), .w2re_destpipe3(w2re_destpipe3),
    .w2d_busy(w2d_busy), .w2d_sberr(w2d_sberr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  function automatic logic [15:0] sb_busy(input logic [15:0] v);
`ifdef WB_SCOREBOARD_EN
    return v;
`else
    return 16'h0 & v;
`endif
  endfunction

  function automatic logic sb_err(input logic v);
`ifdef WB_SCOREBOARD_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  task automatic clear_inputs();
    e2w_validpipe1 = 0; e2w_instpipe1 = 0; e2w_destpipe1 = 0; e2w_datapipe1 = 0;
    e2w_validpipe2 = 0; e2w_instpipe2 = 0; e2w_destpipe2 = 0; e2w_datapipe2 = 0;
    e2w_validpipe3 = 0; e2w_instpipe3 = 0; e2w_destpipe3 = 0; e2w_datapipe3 = 0;
    d2w_issuepipe1 = 0; d2w_destpipe1 = 0;
    d2w_issuepipe2 = 0; d2w_destpipe2 = 0;
    d2w_issuepipe3 = 0; d2w_destpipe3 = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic result(input int p, input logic [3:0] inst, input logic [3:0] dest,
                        input logic [63:0] data);
    case (p)
      1: begin e2w_validpipe1 = 1; e2w_instpipe1 = inst; e2w_destpipe1 = dest; e2w_datapipe1 = data; end
      2: begin e2w_validpipe2 = 1; e2w_instpipe2 = inst; e2w_destpipe2 = dest; e2w_datapipe2 = data; end
      default: begin e2w_validpipe3 = 1; e2w_instpipe3 = inst; e2w_destpipe3 = dest; e2w_datapipe3 = data; end
    endcase
  endtask

  task automatic issue(input int p, input logic [3:0] dest);
    case (p)
      1: begin d2w_issuepipe1 = 1; d2w_destpipe1 = dest; end
      2: begin d2w_issuepipe2 = 1; d2w_destpipe2 = dest; end
      default: begin d2w_issuepipe3 = 1; d2w_destpipe3 = dest; end
    endcase
  endtask

  initial begin
    reset_n = 0;
    flush   = 0;
    clear_inputs();
    repeat (3) @(posedge clock);
    #2 reset_n = 1;
    tick();
    check("rst_wr1", w2r_wrpipe1, 0);
    check("rst_wr2", w2r_wrpipe2, 0);
    check("rst_wr3", w2r_wrpipe3, 0);
    check("rst_data1", w2re_datapipe1, 0);
    check("rst_dest3", w2re_destpipe3, 0);
    check("rst_busy", w2d_busy, 0);
    check("rst_sberr", w2d_sberr, 0);

    // single write on pipe 2
    issue(2, 4'd5); tick(); clear_inputs();
    check("single_busy_set", w2d_busy, sb_busy(16'h0020));
    result(2, 4'b0001, 4'd5, 64'hDEAD_BEEF); tick(); clear_inputs();
    check("single_wr2", w2r_wrpipe2, 1);
    check("single_dest2", w2re_destpipe2, 5);
    check("single_data2", w2re_datapipe2, 64'hDEAD_BEEF);
    check("single_wr1", w2r_wrpipe1, 0);
    check("single_wr3", w2r_wrpipe3, 0);
    check("single_busy_hold", w2d_busy, sb_busy(16'h0020));
    tick();
    check("single_wr2_drop", w2r_wrpipe2, 0);
    check("single_busy_clr", w2d_busy, 0);

    // three-way conflict on r7
    issue(1, 4'd7); issue(2, 4'd7); issue(3, 4'd7); tick(); clear_inputs();
    check("conf_busy_set", w2d_busy, sb_busy(16'h0080));
    result(1, 4'b0010, 4'd7, 64'd1);
    result(2, 4'b0011, 4'd7, 64'd2);
    result(3, 4'b0100, 4'd7, 64'd3);
    tick(); clear_inputs();
    check("conf_wr3", w2r_wrpipe3, 1);
    check("conf_data3", w2re_datapipe3, 3);
    check("conf_dest3", w2re_destpipe3, 7);
    check("conf_wr1", w2r_wrpipe1, 0);
    check("conf_wr2", w2r_wrpipe2, 0);
    tick();
    check("conf_busy_clr", w2d_busy, 0);
    check("conf_sberr", w2d_sberr, 0);

    // NOP opcode does not write
    result(1, 4'b0000, 4'd4, 64'h55); tick(); clear_inputs();
    check("nop_wr1", w2r_wrpipe1, 0);
    tick();
    check("nop_busy", w2d_busy, 0);
    check("nop_sberr", w2d_sberr, 0);

    // scoreboard timing: issue cycle 0, result cycle 2
    issue(1, 4'd9); tick(); clear_inputs();
    check("sb_c1_busy", w2d_busy, sb_busy(16'h0200));
    tick();
    check("sb_c2_busy", w2d_busy, sb_busy(16'h0200));
    result(1, 4'b0011, 4'd9, 64'h99); tick(); clear_inputs();
    check("sb_c3_busy", w2d_busy, sb_busy(16'h0200));
    check("sb_c3_wr1", w2r_wrpipe1, 1);
    tick();
    check("sb_c4_busy", w2d_busy, 0);

    // two issues need two retires
    issue(1, 4'd9); issue(2, 4'd9); tick(); clear_inputs();
    result(1, 4'b0011, 4'd9, 64'd1); tick(); clear_inputs();
    tick();
    check("sb_two_after1", w2d_busy, sb_busy(16'h0200));
    result(3, 4'b0011, 4'd9, 64'd2); tick(); clear_inputs();
    check("sb_two_hold", w2d_busy, sb_busy(16'h0200));
    tick();
    check("sb_two_clr", w2d_busy, 0);

    // issue and retire of r9 on the same edge: net zero keeps busy
    issue(1, 4'd9); tick(); clear_inputs();
    result(2, 4'b0100, 4'd9, 64'd5); tick(); clear_inputs();
    issue(3, 4'd9); tick(); clear_inputs();
    check("sb_net_busy", w2d_busy, sb_busy(16'h0200));
    result(2, 4'b0100, 4'd9, 64'd6); tick(); clear_inputs();
    tick();
    check("sb_net_clr", w2d_busy, 0);
    check("sb_net_sberr", w2d_sberr, 0);

    // overflow: four issues to r3
    issue(1, 4'd3); issue(2, 4'd3); issue(3, 4'd3); tick(); clear_inputs();
    check("ovf_sberr_pre", w2d_sberr, 0);
    issue(1, 4'd3); tick(); clear_inputs();
    check("ovf_sberr", w2d_sberr, sb_err(1'b1));
    check("ovf_busy", w2d_busy, sb_busy(16'h0008));

    // flush discards the presented result and issue
    flush = 1;
    result(1, 4'b0101, 4'd2, 64'h77);
    issue(2, 4'd6);
    tick();
    flush = 0;
    clear_inputs();
    check("flush_busy", w2d_busy, 0);
    check("flush_wr1", w2r_wrpipe1, 0);
    check("flush_sberr", w2d_sberr, sb_err(1'b1));

    // asynchronous reset mid-cycle clears everything
    result(3, 4'b0010, 4'd1, 64'hABC); tick(); clear_inputs();
    check("pre_rst_wr3", w2r_wrpipe3, 1);
    #2 reset_n = 0;
    #1;
    check("arst_wr3", w2r_wrpipe3, 0);
    check("arst_data3", w2re_datapipe3, 0);
    check("arst_dest3", w2re_destpipe3, 0);
    check("arst_busy", w2d_busy, 0);
    check("arst_sberr", w2d_sberr, 0);
    #2 reset_n = 1;
    tick();
    check("post_rst_wr3", w2r_wrpipe3, 0);
    check("post_rst_sberr", w2d_sberr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
